// File: rtl/thermo_dac_driver.sv
// Purpose  : slews a unary/resistor-string DAC toward a binary target, one LSB per step.
// Latency  : done follows the accept edge by 1 + |target - cur_code| * SETTLE_CYCLES clocks.
// Backpress: in_ready is high only in IDLE; requests offered during a move are ignored, not queued.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_code carries a new target this cycle
//   in_code    binary target code
//   in_ready   a target can be accepted this cycle (IDLE and not in reset)
//   therm_out  registered thermometer code to the DAC switches (bit 0 always 0)
//   cur_code   registered binary code currently driven
//   busy       slewing toward the target
//   done       one-cycle pulse once cur_code has reached the target

module thermo_dac_driver #(
   parameter  int N_BITS        = 3,
   parameter  int SETTLE_CYCLES = 4,
   localparam int THERM_W       = 2**N_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [N_BITS-1:0]   in_code,
   output logic                in_ready,
   output logic [THERM_W-1:0]  therm_out,
   output logic [N_BITS-1:0]   cur_code,
   output logic                busy,
   output logic                done
);

   // Settle counter holds 0..SETTLE_CYCLES-1; keep at least one bit so S = 1 still elaborates.
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [N_BITS-1:0] CODE_ONE = N_BITS'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MOVE = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [N_BITS-1:0]  target;
   logic [N_BITS-1:0]  target_nxt;
   logic [N_BITS-1:0]  code_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               done_nxt;
   logic [THERM_W-1:0] therm_nxt;

   // Same format as the ADC comparator bank: bit k set when k <= code, bit 0 unused.
   function automatic logic [THERM_W-1:0] to_therm(input logic [N_BITS-1:0] code);
      logic [THERM_W-1:0] t;
      t = '0;
      for (int k = 1; k < THERM_W; k++) begin
         t[k] = (k <= int'(code));
      end
      return t;
   endfunction

   assign in_ready = (state == IDLE) & ~rst;
   assign busy     = (state == MOVE);

   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      code_nxt   = cur_code;
      cnt_nxt    = cnt;
      done_nxt   = 1'b0;

      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               target_nxt = in_code;
               cnt_nxt    = '0;
               state_nxt  = MOVE;
            end
         end
         MOVE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_ONE;
            end else if (cur_code < target) begin
               code_nxt = cur_code + CODE_ONE;
               cnt_nxt  = CNT_LOAD;
            end else if (cur_code > target) begin
               code_nxt = cur_code - CODE_ONE;
               cnt_nxt  = CNT_LOAD;
            end else begin
               // Settled on the target: pulse done and reopen for the next request.
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Registered from the next code so therm_out and cur_code always change on the same edge.
      therm_nxt = to_therm(code_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         target    <= '0;
         cur_code  <= '0;
         cnt       <= '0;
         done      <= 1'b0;
         therm_out <= '0;
      end else begin
         state     <= state_nxt;
         target    <= target_nxt;
         cur_code  <= code_nxt;
         cnt       <= cnt_nxt;
         done      <= done_nxt;
         therm_out <= therm_nxt;
      end
   end

endmodule

// File: tb/tb_thermo_dac_driver.sv
// Bench for thermo_dac_driver (N_BITS = 3, SETTLE_CYCLES = 4).
// A negedge monitor scores every done pulse against expectations queued at handshake time,
// and checks the thermometer mapping, ADC loopback and single-bit steps on every cycle.

module tb_thermo_dac_driver;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] in_code;
   logic       in_ready;
   logic [7:0] therm_out;
   logic [2:0] cur_code;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      int         cyc;
      logic [2:0] code;
   } exp_t;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } chg_t;

   typedef struct {
      logic [2:0] code;
      int         lat;
      logic [7:0] therm;
   } vec_t;

   exp_t sb[$];
   chg_t chg_log[$];
   vec_t vecs[16];
   logic [7:0] ramp[5];

   logic [2:0] model_code = 3'd0;
   logic [7:0] prev_therm = 8'd0;
   logic       prev_rst   = 1'b1;
   int         d;

   int         acc, acc1, acc2, lat, steps, ec, n_cmp;
   logic [2:0] from_code;
   logic       done_seen;

   thermo_dac_driver #(.N_BITS(3), .SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_code   (in_code),
      .in_ready  (in_ready),
      .therm_out (therm_out),
      .cur_code  (cur_code),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] thermo(input logic [2:0] c);
      logic [7:0] t;
      t = 8'd0;
      for (int k = 1; k < 8; k++) t[k] = (k <= int'(c));
      return t;
   endfunction

   // ADC-side priority encoder: index of the highest set bit, 0 when none.
   function automatic logic [2:0] prio_enc(input logic [7:0] t);
      logic [2:0] e;
      e = 3'd0;
      for (int k = 1; k < 8; k++) if (t[k]) e = 3'(k);
      return e;
   endfunction

   function automatic int popcnt(input logic [7:0] v);
      int n;
      n = 0;
      for (int k = 0; k < 8; k++) if (v[k]) n++;
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples 1 time unit after the falling edge, when inputs and outputs are both stable.
   always begin
      @(negedge clk);
      #1;
      if (mon_en) begin
         if (done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: done=1 at cycle %0d, expected done=0", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("done_cycle", cyc, e.cyc);
               check("done_code", 32'(cur_code), 32'(e.code));
            end
         end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_done: no done by cycle %0d, expected at cycle %0d", cyc, e.cyc);
         end

         check("loopback", 32'(prio_enc(therm_out)), 32'(cur_code));
         check("therm_map", 32'(therm_out), 32'(thermo(cur_code)));
         check("ready_vs_busy", 32'(in_ready), 32'(!busy && !rst));
         if (!prev_rst)
            check("one_bit_step", 32'(popcnt(therm_out ^ prev_therm) <= 1), 32'(1));
         if (therm_out != prev_therm) begin
            chg_t c;
            c.cyc = cyc;
            c.val = therm_out;
            chg_log.push_back(c);
         end
         prev_therm = therm_out;

         // Expectations for the upcoming edge (cyc + 1).
         if (rst) begin
            sb.delete();
            model_code = 3'd0;
         end else if (in_valid && in_ready) begin
            exp_t e;
            d = (int'(in_code) > int'(model_code)) ? int'(in_code) - int'(model_code)
                                                   : int'(model_code) - int'(in_code);
            e.cyc  = cyc + 2 + d * S;
            e.code = in_code;
            sb.push_back(e);
            model_code = in_code;
         end
         prev_rst = rst;
      end
   end

   // Called at a falling edge; returns at the falling edge right after the accept edge.
   task automatic send(input logic [2:0] c, output int acc_o);
      acc_o    = -1;
      in_valid = 1'b1;
      in_code  = c;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin
            acc_o = cyc + 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (acc_o < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready=0 for 100 cycles, expected 1");
      end
   endtask

   task automatic wait_done(input int acc_i, output int lat_o);
      lat_o = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            lat_o = cyc - acc_i;
            break;
         end
         check("busy_in_move", 32'(busy), 32'(1));
         check("ready_low_in_move", 32'(in_ready), 32'(0));
      end
      if (lat_o < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: done=0 for 400 cycles, expected a pulse");
      end
   endtask

   initial begin
      #200000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected test end");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      vecs[0]  = '{3'd5, 21, 8'b00111110};
      vecs[1]  = '{3'd2, 13, 8'b00000110};
      vecs[2]  = '{3'd2,  1, 8'b00000110};
      vecs[3]  = '{3'd7, 21, 8'b11111110};
      vecs[4]  = '{3'd0, 29, 8'b00000000};
      vecs[5]  = '{3'd3, 13, 8'b00001110};
      vecs[6]  = '{3'd4,  5, 8'b00011110};
      vecs[7]  = '{3'd1, 13, 8'b00000010};
      vecs[8]  = '{3'd0,  5, 8'b00000000};
      vecs[9]  = '{3'd1,  5, 8'b00000010};
      vecs[10] = '{3'd2,  5, 8'b00000110};
      vecs[11] = '{3'd3,  5, 8'b00001110};
      vecs[12] = '{3'd4,  5, 8'b00011110};
      vecs[13] = '{3'd5,  5, 8'b00111110};
      vecs[14] = '{3'd6,  5, 8'b01111110};
      vecs[15] = '{3'd7,  5, 8'b11111110};
      ramp = '{8'b00000010, 8'b00000110, 8'b00001110, 8'b00011110, 8'b00111110};

      // Reset held for three edges.
      rst      = 1'b1;
      in_valid = 1'b0;
      in_code  = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_therm", 32'(therm_out), 32'(0));
      check("rst_code", 32'(cur_code), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_ready", 32'(in_ready), 32'(0));
      mon_en = 1'b1;
      rst    = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(in_ready), 32'(1));

      // Table-driven moves, ending with a one-LSB sweep through every code.
      from_code = 3'd0;
      for (int i = 0; i < 16; i++) begin
         chg_log.delete();
         send(vecs[i].code, acc);
         wait_done(acc, lat);
         check("vec_latency", lat, vecs[i].lat);
         check("vec_therm", 32'(therm_out), 32'(vecs[i].therm));
         check("vec_code", 32'(cur_code), 32'(vecs[i].code));
         steps = (vecs[i].lat - 1) / S;
         check("vec_n_steps", chg_log.size(), steps);
         n_cmp = (chg_log.size() < steps) ? chg_log.size() : steps;
         for (int k = 0; k < n_cmp; k++) begin
            ec = (vecs[i].code > from_code) ? int'(from_code) + k + 1 : int'(from_code) - k - 1;
            check("step_cycle", chg_log[k].cyc, acc + 1 + k * S);
            check("step_value", 32'(chg_log[k].val), 32'(thermo(3'(ec))));
            if (i == 0) check("upramp_value", 32'(chg_log[k].val), 32'(ramp[k]));
         end
         from_code = vecs[i].code;
      end

      // Request held through a move: ignored until done, then accepted back-to-back.
      in_valid = 1'b1;
      in_code  = 3'd4;
      check("hold_ready", 32'(in_ready), 32'(1));
      acc1 = cyc + 1;
      @(negedge clk);
      in_code = 3'd7;
      wait_done(acc1, lat);
      check("hold_latency", lat, 13);
      check("hold_code", 32'(cur_code), 32'(4));
      check("ready_on_done", 32'(in_ready), 32'(1));
      acc2 = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_busy", 32'(busy), 32'(1));
      check("b2b_no_step_yet", 32'(cur_code), 32'(4));
      @(negedge clk);
      check("b2b_first_step", 32'(cur_code), 32'(5));
      wait_done(acc2, lat);
      check("b2b_latency", lat, 13);
      check("b2b_code", 32'(cur_code), 32'(7));

      // Reset during the third step of a 0 -> 7 move.
      send(3'd0, acc);
      wait_done(acc, lat);
      check("full_down_latency", lat, 29);
      send(3'd7, acc);
      for (int i = 0; i < 20 && cyc < acc + 10; i++) @(negedge clk);
      check("third_step_code", 32'(cur_code), 32'(3));
      check("third_step_busy", 32'(busy), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      check("midrst_therm", 32'(therm_out), 32'(0));
      check("midrst_code", 32'(cur_code), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_done", 32'(done), 32'(0));
      check("midrst_ready", 32'(in_ready), 32'(0));
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      check("no_done_after_rst", 32'(done_seen), 32'(0));
      check("idle_after_rst", 32'(busy), 32'(0));
      check("code_after_rst", 32'(cur_code), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
